// File: rtl/msx_arb_pkg.sv
// Shared types for the MSX RAM arbiter: FSM states, requester IDs and the
// latched single-byte transaction record.
package msx_arb_pkg;

    // Byte-address width carried in the transaction record.
    localparam int RAM_AW = 27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_CPU  = 2'd1,
        SRC_LDR  = 2'd2,
        SRC_BKP  = 2'd3
    } arb_src_t;

    typedef struct packed {
        logic [RAM_AW-1:0] addr;
        logic [7:0]        din;
        logic              rnw;
        logic              sdram;
    } ram_req_t;

endpackage

// File: rtl/msx_arb_select.sv
// Fixed-priority winner pick: CPU > loader > backup. cpu_block removes the
// CPU from the pick so a starved lower requester can get through.
module msx_arb_select
    import msx_arb_pkg::*;
(
    input  logic     cpu_req,
    input  logic     ldr_req,
    input  logic     bkp_req,
    input  logic     cpu_block,
    output arb_src_t winner
);

    // Priority encoder over the three level requests.
    always_comb begin
        winner = SRC_NONE;
        if (cpu_req && !cpu_block) begin
            winner = SRC_CPU;
        end else if (ldr_req) begin
            winner = SRC_LDR;
        end else if (bkp_req) begin
            winner = SRC_BKP;
        end
    end

endmodule

// File: rtl/msx_ram_arbiter.sv
// Shares one RAM port (SDRAM / BRAM chip-selects) between the CPU slot
// datapath, the ROM loader and the SRAM backup engine, one byte at a time.
// Optional anti-starvation for the CPU is enabled by MSX_ARB_FAIRNESS_EN.
//
// Handshake: a requester holds its req level until it sees its one-cycle
// ack and drops req in the cycle after ack. Requests are sampled only in
// IDLE, so a req still high in the next IDLE starts a new transaction.
// Read data (cpu_dout/bkp_dout) is valid with ack and held until the next
// read completes for that requester.
module msx_ram_arbiter
    import msx_arb_pkg::*;
#(
    parameter int AW           = 27,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          ldr_req,
    input  logic          bkp_req,
    input  logic [AW-1:0] cpu_addr,
    input  logic [AW-1:0] ldr_addr,
    input  logic [AW-1:0] bkp_addr,
    input  logic [7:0]    cpu_din,
    input  logic [7:0]    ldr_din,
    input  logic [7:0]    bkp_din,
    input  logic          cpu_rnw,
    input  logic          bkp_rnw,
    input  logic          cpu_sdram,
    input  logic          ldr_sdram,
    input  logic          bkp_sdram,
    output logic          cpu_ack,
    output logic          ldr_ack,
    output logic          bkp_ack,
    output logic [7:0]    cpu_dout,
    output logic [7:0]    bkp_dout,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_rnw,
    output logic          sdram_ce,
    output logic          bram_ce,
    input  logic [7:0]    ram_dout,
    input  logic          sdram_ready,
    output logic [1:0]    grant,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Parameter sanity: the transaction record is sized from the package.
    if (AW != RAM_AW) begin : g_aw_check
        $error("msx_ram_arbiter: AW must equal msx_arb_pkg::RAM_AW");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_starve_check
        $error("msx_ram_arbiter: STARVE_LIMIT out of range 1..255");
    end

    arb_state_t state_q;
    arb_src_t   grant_q;
    arb_src_t   winner;
    ram_req_t   txn_q;
    ram_req_t   txn_d;
    logic       sdram_ce_q, bram_ce_q;
    logic       cpu_ack_q, ldr_ack_q, bkp_ack_q;
    logic [7:0] cpu_dout_q, bkp_dout_q;
    logic       cpu_block;

`ifdef MSX_ARB_FAIRNESS_EN
    logic [7:0] starve_cnt_q;

    // Once the CPU has won STARVE_LIMIT times over a waiting requester,
    // hand the next arbitration to the lower requester.
    assign cpu_block = (starve_cnt_q == 8'(STARVE_LIMIT)) && (ldr_req || bkp_req);

    // Count CPU grants made over a pending lower requester; any other grant clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= 8'd0;
        end else if (state_q == ST_IDLE && winner != SRC_NONE) begin
            if (winner != SRC_CPU) begin
                starve_cnt_q <= 8'd0;
            end else if (ldr_req || bkp_req) begin
                starve_cnt_q <= starve_cnt_q + 8'd1;
            end
        end
    end
`else
    assign cpu_block = 1'b0;
`endif

    msx_arb_select u_select (
        .cpu_req   (cpu_req),
        .ldr_req   (ldr_req),
        .bkp_req   (bkp_req),
        .cpu_block (cpu_block),
        .winner    (winner)
    );

    // Route the winner's fields into the candidate transaction record.
    always_comb begin
        txn_d = '0;
        case (winner)
            SRC_CPU: txn_d = '{addr: cpu_addr, din: cpu_din, rnw: cpu_rnw, sdram: cpu_sdram};
            SRC_LDR: txn_d = '{addr: ldr_addr, din: ldr_din, rnw: 1'b0,    sdram: ldr_sdram};
            SRC_BKP: txn_d = '{addr: bkp_addr, din: bkp_din, rnw: bkp_rnw, sdram: bkp_sdram};
            default: txn_d = '0;
        endcase
    end

    // Transaction FSM: IDLE -> ISSUE -> WAIT -> DONE, with registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= SRC_NONE;
            txn_q      <= '0;
            sdram_ce_q <= 1'b0;
            bram_ce_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            ldr_ack_q  <= 1'b0;
            bkp_ack_q  <= 1'b0;
            cpu_dout_q <= 8'd0;
            bkp_dout_q <= 8'd0;
        end else begin
            sdram_ce_q <= 1'b0;
            bram_ce_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            ldr_ack_q  <= 1'b0;
            bkp_ack_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (winner != SRC_NONE) begin
                        txn_q      <= txn_d;
                        grant_q    <= winner;
                        sdram_ce_q <= txn_d.sdram;
                        bram_ce_q  <= !txn_d.sdram;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    // BRAM answers in one cycle; SDRAM waits for ready.
                    if (!txn_q.sdram || sdram_ready) begin
                        if (txn_q.rnw && grant_q == SRC_CPU) cpu_dout_q <= ram_dout;
                        if (txn_q.rnw && grant_q == SRC_BKP) bkp_dout_q <= ram_dout;
                        cpu_ack_q <= (grant_q == SRC_CPU);
                        ldr_ack_q <= (grant_q == SRC_LDR);
                        bkp_ack_q <= (grant_q == SRC_BKP);
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    grant_q <= SRC_NONE;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ram_addr  = txn_q.addr;
    assign ram_din   = txn_q.din;
    assign ram_rnw   = txn_q.rnw;
    assign sdram_ce  = sdram_ce_q;
    assign bram_ce   = bram_ce_q;
    assign cpu_ack   = cpu_ack_q;
    assign ldr_ack   = ldr_ack_q;
    assign bkp_ack   = bkp_ack_q;
    assign cpu_dout  = cpu_dout_q;
    assign bkp_dout  = bkp_dout_q;
    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: doc/msx_ram_arbiter.md
# msx_ram_arbiter

Sequential arbiter that shares the single RAM port (SDRAM plus BRAM chip-selects) between three requesters: the CPU slot datapath, the ROM/cartridge image loader, and the SRAM backup save/load engine. It sits between those requesters and the memory controller pins `ram_addr`, `ram_din`, `ram_rnw`, `sdram_ce`, `bram_ce`, `ram_dout`. Each transaction is a single byte, carried through a 4-state FSM with a per-requester req/ack handshake.

## Interface
Parameters:
- `AW`, 27: RAM byte-address width.
- `STARVE_LIMIT`, 8: consecutive CPU grants tolerated while a lower requester waits. Used only with the fairness feature; range 1–255.

Ports:
- `clk`, in, 1: system clock, the single clock of the block.
- `reset`, in, 1: synchronous, active-high.
- `cpu_req`, `ldr_req`, `bkp_req`, in, 1 each: level request per requester.
- `cpu_addr`, `ldr_addr`, `bkp_addr`, in, AW each: byte address.
- `cpu_din`, `ldr_din`, `bkp_din`, in, 8 each: write data.
- `cpu_rnw`, `bkp_rnw`, in, 1 each: 1 = read. The loader is write-only.
- `cpu_sdram`, `ldr_sdram`, `bkp_sdram`, in, 1 each: target select, 1 = SDRAM, 0 = BRAM.
- `cpu_ack`, `ldr_ack`, `bkp_ack`, out, 1 each: one-cycle completion pulse.
- `cpu_dout`, `bkp_dout`, out, 8 each: read data, valid while the matching ack is high and held until the next ack.
- `ram_addr`, out, AW; `ram_din`, out, 8; `ram_rnw`, out, 1: memory port.
- `sdram_ce`, `bram_ce`, out, 1 each: one-cycle issue strobes.
- `ram_dout`, in, 8: memory read data.
- `sdram_ready`, in, 1: SDRAM transaction complete.
- `grant`, out, 2: 0 = none, 1 = CPU, 2 = loader, 3 = backup.
- `busy`, out, 1: FSM not in IDLE.

## Operation
- FSM states are IDLE, ISSUE, WAIT and DONE.
- **IDLE**
  - Requests are sampled only in this state.
  - If any request is high, the winner's addr, din, rnw and sdram fields are latched into the transaction register.
  - `grant` is set and the FSM moves to ISSUE. Otherwise the FSM stays in IDLE.
- **ISSUE**
  - Drive `ram_*` from the transaction register.
  - Pulse `sdram_ce` or `bram_ce` for exactly one cycle.
  - Move to WAIT.
- **WAIT**
  - BRAM: the FSM stays exactly one cycle. Capture `ram_dout` if reading, then move to DONE.
  - SDRAM: the FSM stays until `sdram_ready` = 1. In that cycle, capture `ram_dout` if reading, then move to DONE.
- **DONE**
  - Pulse the granted requester's ack.
  - Clear `grant`.
  - Move to IDLE.
- `ram_addr`, `ram_din` and `ram_rnw` hold the latched values from ISSUE through DONE.
- Priority, fixed: CPU > loader > backup. The loader always beats backup.
- Requester rule: drop req in the cycle after ack. A req still high in the following IDLE is treated as a new transaction.
- Loader writes with `ldr_sdram` = 0 go to BRAM. The arbiter does no address translation.
- `sdram_ready` outside WAIT is ignored.
- Reset
  - Reset in any state: FSM to IDLE.
  - All ce and ack outputs go to 0, `grant` = 0, `busy` = 0, `ram_*` = 0, dout registers = 0, fairness counter = 0.
  - An in-flight transaction is dropped without an ack. The requester must reissue.

## Timing
- Request high in IDLE at cycle N:
  - ISSUE, with ce high, at N+1.
  - WAIT at N+2.
  - BRAM: DONE/ack at N+3.
  - SDRAM: ack one cycle after the first cycle `sdram_ready` is high in WAIT.
- Back-to-back transactions: the next issue is 2 cycles after an ack (DONE → IDLE → ISSUE).
- Simultaneous requests in IDLE: the highest-priority requester wins. Losers stay pending with no ack.
- `sdram_ready` already high in the first WAIT cycle: DONE follows on the next cycle.

## Configuration
- `MSX_ARB_FAIRNESS_EN` defined:
  - An 8-bit counter increments on each CPU grant made while `ldr_req` or `bkp_req` is pending.
  - When the counter equals `STARVE_LIMIT`, the next arbitration excludes the CPU and the counter clears.
  - Any non-CPU grant also clears the counter.
- Macro undefined: strict priority. The counter logic is absent and the `STARVE_LIMIT` parameter is unused.

## Structure
- Package `msx_arb_pkg` holds:
  - `arb_state_t`: the enum IDLE/ISSUE/WAIT/DONE.
  - `arb_src_t`: the 2-bit requester ID enum, NONE/CPU/LDR/BKP.
  - `ram_req_t`: a struct of addr, din, rnw, sdram.
- Sub-module `msx_arb_select`:
  - Combinational winner pick from the three reqs plus a `cpu_block` input.
  - The fairness counter lives in the parent, inside the `MSX_ARB_FAIRNESS_EN` guard.

## Test plan
- **Lone CPU BRAM read.** `cpu_req`=1, `cpu_addr`=0x00100, `cpu_sdram`=0, memory returns 0x5A. Required: `bram_ce` pulse at N+1, `cpu_ack` at N+3, `cpu_dout`=0x5A, `sdram_ce` never asserted.
- **Loader SDRAM write.** `ldr_addr`=0x1234567, `ldr_din`=0xA5, `sdram_ready` after 5 WAIT cycles. Required: `sdram_ce` one cycle, `ram_rnw`=0, addr/data held through DONE, `ldr_ack` one cycle after `sdram_ready`.
- **Simultaneous requests.** All three req high in the same IDLE cycle. Required: grant order CPU, loader, backup over three transactions, each ack single-cycle.
- **Fairness**, run with `MSX_ARB_FAIRNESS_EN` and `STARVE_LIMIT`=4. CPU re-requests continuously while `bkp_req` is held. Required: backup granted after exactly 4 CPU grants. Repeat without the macro: backup is never granted while the CPU requests.
- **Reset in WAIT.** Assert `reset` for 1 cycle during an SDRAM read. Required: no ack, FSM in IDLE, all outputs 0 the next cycle, a fresh request then completes normally.
